// File: rtl/exc_arbiter.sv
// Commit-stage exception arbiter: merges interrupts, synchronous exceptions and ERET into one
// cp0 event, flushes the pipeline and hands fetch a redirect PC over a valid/ready handshake.
module exc_arbiter #(
  parameter logic [31:0] EXC_VECTOR  = 32'hBFC00380,
  parameter int          SYNC_STAGES = 2,
  parameter logic [4:0]  ERET_CODE   = 5'h0e
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [5:0]  ext_int_in,
  input  logic        m_valid,
  input  logic [31:0] m_pc,
  input  logic        m_is_delay_slot,
  input  logic        m_exc_valid,
  input  logic [4:0]  m_exccode,
  input  logic [31:0] m_badvaddr,
  input  logic        m_is_eret,
  input  logic [7:0]  cause_ip,
  input  logic [7:0]  status_im,
  input  logic        status_ie,
  input  logic        status_exl,
  input  logic [31:0] epc,
  output logic [5:0]  cp0_interrupt,
  output logic        cp0_exception,
  output logic [4:0]  cp0_exccode,
  output logic        cp0_is_delay_slot,
  output logic [31:0] cp0_pc,
  output logic [31:0] cp0_badvaddr,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ready
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SIGNAL   = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  state_t      state;
  logic [5:0]  sync_q [SYNC_STAGES];
  logic        int_pending;
  logic        exc_event;
  logic [4:0]  event_code;
  logic [31:0] event_target;

  // Level synchroniser for the asynchronous interrupt lines
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 6'd0;
    end else begin
      sync_q[0] <= ext_int_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign cp0_interrupt = sync_q[SYNC_STAGES-1];

  assign int_pending = status_ie & ~status_exl & (|(cause_ip & status_im));
  assign exc_event   = (state == IDLE) & m_valid & (int_pending | m_exc_valid | m_is_eret);
  assign flush       = exc_event | (state != IDLE);

  // Event code and redirect target, interrupt first, then exception, then ERET
  always_comb begin
    event_code   = 5'd0;
    event_target = EXC_VECTOR;
    if (int_pending) begin
      event_code = 5'd0;
    end else if (m_exc_valid) begin
      event_code = m_exccode;
    end else if (m_is_eret) begin
      event_code   = ERET_CODE;
      event_target = epc;
    end else begin
      event_code = 5'd0;
    end
  end

  // Event FSM with registered strobe, sideband and redirect outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state             <= IDLE;
      cp0_exception     <= 1'b0;
      cp0_exccode       <= 5'd0;
      cp0_is_delay_slot <= 1'b0;
      cp0_pc            <= 32'd0;
      cp0_badvaddr      <= 32'd0;
      redirect_valid    <= 1'b0;
      redirect_pc       <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (exc_event) begin
            state             <= SIGNAL;
            cp0_exception     <= 1'b1;
            cp0_exccode       <= event_code;
            cp0_is_delay_slot <= m_is_delay_slot;
            cp0_pc            <= m_pc;
            cp0_badvaddr      <= m_badvaddr;
            redirect_valid    <= 1'b1;
            redirect_pc       <= event_target;
          end else begin
            cp0_exception <= 1'b0;
          end
        end
        SIGNAL: begin
          cp0_exception <= 1'b0;
          if (redirect_ready) begin
            state          <= IDLE;
            redirect_valid <= 1'b0;
          end else begin
            state <= REDIRECT;
          end
        end
        REDIRECT: begin
          cp0_exception <= 1'b0;
          if (redirect_ready) begin
            state          <= IDLE;
            redirect_valid <= 1'b0;
          end else begin
            state <= REDIRECT;
          end
        end
        default: begin
          state          <= IDLE;
          cp0_exception  <= 1'b0;
          redirect_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
